vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator: horizontal/vertical position counters, sync, visibility, line/frame strobes and a frame counter. It supersedes the fixed 640x480 sync block. It sits between the pixel clock domain top-level and the renderer. Additions over the fixed block:

- All timings are parameters.
- A pixel-enable input supports divided pixel rates.
- Sync polarity is selectable.
- A configurable delay pipeline keeps sync and visibility aligned with a multi-stage renderer.

---
 rtl/vga_timing_if.sv | 26 ++
 rtl/vga_timing_gen.sv | 146 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_if.sv
// Raster timing bundle between the timing generator (master) and the renderer (slave).
interface vga_timing_if #(
  parameter int unsigned HW      = 10,
  parameter int unsigned VW      = 10,
  parameter int unsigned FRAME_W = 8
);
  logic               pix_en;
  logic [HW-1:0]      px;
  logic [VW-1:0]      py;
  logic               visible;
  logic               hsync;
  logic               vsync;
  logic               line_tick;
  logic               frame_tick;
  logic [FRAME_W-1:0] frame_cnt;

  modport master (
    input  pix_en,
    output px, py, visible, hsync, vsync, line_tick, frame_tick, frame_cnt
  );

  modport slave (
    output pix_en,
    input  px, py, visible, hsync, vsync, line_tick, frame_tick, frame_cnt
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: position counters, sync/visible with a
// pix_en-clocked alignment delay, undelayed line/frame strobes and a frame counter.
module vga_timing_gen #(
  parameter int unsigned H_DISPLAY  = 640,
  parameter int unsigned H_FRONT    = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned V_DISPLAY  = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33,
  parameter int unsigned HW         = 10,
  parameter int unsigned VW         = 10,
  parameter bit          H_SYNC_POL = 1'b1,
  parameter bit          V_SYNC_POL = 1'b1,
  parameter int unsigned PIPE_DELAY = 1,
  parameter int unsigned FRAME_W    = 8
) (
  input  logic         clk,
  input  logic         reset,
  vga_timing_if.master bus
);

  localparam int unsigned HTotal = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VTotal = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  // Totals must fit the counters; the last sync column/row then fits as well.
  if (HTotal > (1 << HW)) begin : g_h_width_check
    $error("vga_timing_gen: horizontal total does not fit in HW bits");
  end
  if (VTotal > (1 << VW)) begin : g_v_width_check
    $error("vga_timing_gen: vertical total does not fit in VW bits");
  end
  if (PIPE_DELAY > 8) begin : g_delay_check
    $error("vga_timing_gen: PIPE_DELAY must be in 0..8");
  end

  localparam logic [HW-1:0] HMax  = HW'(HTotal - 1);
  localparam logic [VW-1:0] VMax  = VW'(VTotal - 1);
  localparam logic [HW-1:0] HDisp = HW'(H_DISPLAY);
  localparam logic [VW-1:0] VDisp = VW'(V_DISPLAY);
  localparam logic [HW-1:0] HSs   = HW'(H_DISPLAY + H_FRONT);
  localparam logic [HW-1:0] HSe   = HW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [VW-1:0] VSs   = VW'(V_DISPLAY + V_FRONT);
  localparam logic [VW-1:0] VSe   = VW'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [HW-1:0]      px_q, px_d;
  logic [VW-1:0]      py_q, py_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic               at_h_max, at_v_max;
  logic               line_tick, frame_tick;
  logic [2:0]         stage0;     // {vis, hs, vs} from the current counters
  logic [2:0]         stage_out;  // {vis, hs, vs} after the alignment delay

  // Strobes are undelayed and suppressed while reset is held.
  always_comb begin
    at_h_max   = (px_q == HMax);
    at_v_max   = (py_q == VMax);
    line_tick  = bus.pix_en && at_h_max && !reset;
    frame_tick = line_tick && at_v_max;
  end

  // Counter and frame-count next state; everything holds while pix_en is low.
  always_comb begin
    px_d        = px_q;
    py_d        = py_q;
    frame_cnt_d = frame_cnt_q;
    if (bus.pix_en) begin
      if (at_h_max) begin
        px_d = '0;
        py_d = at_v_max ? '0 : py_q + VW'(1);
      end else begin
        px_d = px_q + HW'(1);
      end
    end
    if (frame_tick) begin
      frame_cnt_d = frame_cnt_q + FRAME_W'(1);
    end
  end

  // Counter state register, synchronous reset wins over pix_en.
  always_ff @(posedge clk) begin
    if (reset) begin
      px_q        <= '0;
      py_q        <= '0;
      frame_cnt_q <= '0;
    end else begin
      px_q        <= px_d;
      py_q        <= py_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Raw visibility and sync decode from the current counter values.
  always_comb begin
    stage0[2] = (px_q < HDisp) && (py_q < VDisp);
    stage0[1] = (px_q >= HSs) && (px_q <= HSe);
    stage0[0] = (py_q >= VSs) && (py_q <= VSe);
  end

  if (PIPE_DELAY == 0) begin : g_no_delay
    assign stage_out = stage0;
  end else begin : g_delay
    logic [2:0] pipe_q [PIPE_DELAY];
    logic [2:0] pipe_d [PIPE_DELAY];

    // Shift the decode one stage per pixel strobe.
    always_comb begin
      for (int unsigned i = 0; i < PIPE_DELAY; i++) begin
        pipe_d[i] = pipe_q[i];
      end
      if (bus.pix_en) begin
        pipe_d[0] = stage0;
        for (int unsigned i = 1; i < PIPE_DELAY; i++) begin
          pipe_d[i] = pipe_q[i-1];
        end
      end
    end

    // Pipeline register; reset clears every stage so no stale sync escapes.
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int unsigned i = 0; i < PIPE_DELAY; i++) begin
          pipe_q[i] <= 3'b000;
        end
      end else begin
        for (int unsigned i = 0; i < PIPE_DELAY; i++) begin
          pipe_q[i] <= pipe_d[i];
        end
      end
    end

    assign stage_out = pipe_q[PIPE_DELAY-1];
  end

  assign bus.px         = px_q;
  assign bus.py         = py_q;
  assign bus.frame_cnt  = frame_cnt_q;
  assign bus.line_tick  = line_tick;
  assign bus.frame_tick = frame_tick;
  assign bus.visible    = stage_out[2];
  // Idle (hs/vs = 0) drives the inverse of the active level.
  assign bus.hsync      = stage_out[1] ^ ~H_SYNC_POL;
  assign bus.vsync      = stage_out[0] ^ ~V_SYNC_POL;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations driven with random pixel strobes and
// reset pulses, compared every cycle against a strobe-count reference model.
module tb_vga_timing_gen;

  typedef struct {
    int unsigned hd, hf, hs, hb, vd, vf, vs, vb, d, fw;
    bit          hpol, vpol;
  } cfg_t;

  typedef struct {
    logic [31:0] px, py, vis, hs, vs, lt, ft, fc;
  } vec_t;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  // Defaults: 640x480, PIPE_DELAY 1, active-high syncs.
  vga_timing_if #(.HW(10), .VW(10), .FRAME_W(8)) if_a ();
  // Tiny raster, PIPE_DELAY 3, active-low syncs, 2-bit frame counter.
  vga_timing_if #(.HW(4), .VW(3), .FRAME_W(2)) if_b ();
  // Totals exactly fill the counters, no delay.
  vga_timing_if #(.HW(4), .VW(3), .FRAME_W(3)) if_c ();

  vga_timing_gen u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (if_a)
  );

  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HW(4), .VW(3), .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0),
    .PIPE_DELAY(3), .FRAME_W(2)
  ) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (if_b)
  );

  vga_timing_gen #(
    .H_DISPLAY(10), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
    .V_DISPLAY(5), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HW(4), .VW(3), .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1),
    .PIPE_DELAY(0), .FRAME_W(3)
  ) u_dut_c (
    .clk   (clk),
    .reset (reset),
    .bus   (if_c)
  );

  always #5 clk = ~clk;

  cfg_t        cfg_a, cfg_b, cfg_c;
  int unsigned n_a, n_b, n_c;  // pixel strobes accepted since the last reset

  // Expected outputs after n strobes: position is n split into line/column, delayed
  // outputs are the raster decode of strobe n-d (inactive before d strobes).
  function automatic vec_t model(input int unsigned n, input bit en, input bit rst,
                                 input cfg_t c);
    vec_t        m;
    int unsigned ht, vt, k, x, y;
    bit          vis, hs, vs;
    ht   = c.hd + c.hf + c.hs + c.hb;
    vt   = c.vd + c.vf + c.vs + c.vb;
    m.px = n % ht;
    m.py = (n / ht) % vt;
    m.fc = (n / (ht * vt)) % (1 << c.fw);
    vis  = 1'b0;
    hs   = 1'b0;
    vs   = 1'b0;
    if (n >= c.d) begin
      k   = n - c.d;
      x   = k % ht;
      y   = (k / ht) % vt;
      vis = (x < c.hd) && (y < c.vd);
      hs  = (x >= c.hd + c.hf) && (x < c.hd + c.hf + c.hs);
      vs  = (y >= c.vd + c.vf) && (y < c.vd + c.vf + c.vs);
    end
    m.vis = {31'd0, vis};
    m.hs  = {31'd0, hs == c.hpol};
    m.vs  = {31'd0, vs == c.vpol};
    m.lt  = {31'd0, en && !rst && (m.px == ht - 1)};
    m.ft  = {31'd0, en && !rst && (m.px == ht - 1) && (m.py == vt - 1)};
    return m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s at %0t: observed %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic chk_vec(input string nm, input vec_t o, input vec_t e);
    chk({nm, ".px"}, o.px, e.px);
    chk({nm, ".py"}, o.py, e.py);
    chk({nm, ".visible"}, o.vis, e.vis);
    chk({nm, ".hsync"}, o.hs, e.hs);
    chk({nm, ".vsync"}, o.vs, e.vs);
    chk({nm, ".line_tick"}, o.lt, e.lt);
    chk({nm, ".frame_tick"}, o.ft, e.ft);
    chk({nm, ".frame_cnt"}, o.fc, e.fc);
  endtask

  // One clock: apply inputs after the falling edge, check, then advance the model.
  task automatic step(input bit r, input bit ea, input bit eb, input bit ec);
    vec_t oa, ob, oc;
    @(negedge clk);
    reset       = r;
    if_a.pix_en = ea;
    if_b.pix_en = eb;
    if_c.pix_en = ec;
    #1;
    oa = '{32'(if_a.px), 32'(if_a.py), 32'(if_a.visible), 32'(if_a.hsync),
           32'(if_a.vsync), 32'(if_a.line_tick), 32'(if_a.frame_tick), 32'(if_a.frame_cnt)};
    ob = '{32'(if_b.px), 32'(if_b.py), 32'(if_b.visible), 32'(if_b.hsync),
           32'(if_b.vsync), 32'(if_b.line_tick), 32'(if_b.frame_tick), 32'(if_b.frame_cnt)};
    oc = '{32'(if_c.px), 32'(if_c.py), 32'(if_c.visible), 32'(if_c.hsync),
           32'(if_c.vsync), 32'(if_c.line_tick), 32'(if_c.frame_tick), 32'(if_c.frame_cnt)};
    chk_vec("a", oa, model(n_a, ea, r, cfg_a));
    chk_vec("b", ob, model(n_b, eb, r, cfg_b));
    chk_vec("c", oc, model(n_c, ec, r, cfg_c));
    n_a = r ? 0 : n_a + 32'(ea);
    n_b = r ? 0 : n_b + 32'(eb);
    n_c = r ? 0 : n_c + 32'(ec);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    clk         = 1'b0;
    reset       = 1'b1;
    if_a.pix_en = 1'b0;
    if_b.pix_en = 1'b0;
    if_c.pix_en = 1'b0;
    cfg_a = '{hd: 640, hf: 16, hs: 96, hb: 48, vd: 480, vf: 10, vs: 2, vb: 33,
              d: 1, fw: 8, hpol: 1'b1, vpol: 1'b1};
    cfg_b = '{hd: 8, hf: 1, hs: 2, hb: 1, vd: 4, vf: 1, vs: 1, vb: 1,
              d: 3, fw: 2, hpol: 1'b0, vpol: 1'b0};
    cfg_c = '{hd: 10, hf: 2, hs: 3, hb: 1, vd: 5, vf: 1, vs: 1, vb: 1,
              d: 0, fw: 3, hpol: 1'b1, vpol: 1'b1};
    repeat (2) @(negedge clk);
    n_a = 0;
    n_b = 0;
    n_c = 0;

    // Held in reset with strobes high: state stays cleared, ticks stay low.
    repeat (3) step(1'b1, 1'b1, 1'b1, 1'b1);

    // Continuous strobes on the default raster: several full lines.
    for (int i = 0; i < 2500; i++) begin
      step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Mid-frame reset pulse, then recovery through the pipeline.
    step(1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      step(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 1)));
    end

    // Reset while strobes are idle, then every-other-clock strobes.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2000; i++) begin
      step(1'b0, 1'(i % 2), 1'(i % 2), 1'((i + 1) % 2));
    end

    // Random short reset pulses scattered through random traffic.
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
